// File: rtl/tick_stopwatch_512.sv
// -----------------------------------------------------------------------------
// tick_stopwatch_512
//
// Consumer of the 512 Hz divided clock. The slow square wave clk_512_in is
// synchronised into the clk domain and its rising edges become single-cycle
// ticks. Those ticks drive a start/stop/clear stopwatch (min:sec:frac at
// 1/TICKS_PER_SEC s resolution). The block also has a lap capture register and
// a watchdog that flags a missing tick stream.
//
// Parameters
//   TICKS_PER_SEC   ticks per second; frac wraps at this value (<= 512)
//   MAX_MIN         minutes wrap value; minutes run 0..MAX_MIN (<= 127)
//   SYNC_STAGES     flops in the clk_512_in synchroniser (>= 2)
//   TIMEOUT_CYCLES  clk cycles without a tick before tick_lost sets
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   clk_512_in      divided clock, treated as asynchronous data
//   start/stop      one-cycle pulses: IDLE/PAUSE -> RUN, RUN -> PAUSE
//   clear           one-cycle pulse: -> IDLE, time, laps and tick_lost zeroed
//   lap             one-cycle pulse: capture current time (RUN/PAUSE only)
//   frac/sec/min    running time
//   running         high while in RUN
//   lap_frac/sec/min captured time, lap_valid pulses once per accepted lap
//   overflow        one-cycle pulse when the time wraps to 0:00:0
//   tick_lost       sticky watchdog flag
// -----------------------------------------------------------------------------
module tick_stopwatch_512 #(
    parameter int TICKS_PER_SEC  = 512,
    parameter int MAX_MIN        = 99,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_512_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [8:0] frac,
    output logic [5:0] sec,
    output logic [6:0] min,
    output logic       running,
    output logic [8:0] lap_frac,
    output logic [5:0] lap_sec,
    output logic [6:0] lap_min,
    output logic       lap_valid,
    output logic       overflow,
    output logic       tick_lost
);

    localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT_CYCLES);
    localparam logic [8:0]      FRAC_LAST = 9'(TICKS_PER_SEC - 1);
    localparam logic [6:0]      MIN_LAST  = 7'(MAX_MIN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;
    logic                   tick;
    logic [WD_W-1:0]        wd_cnt, wd_nxt;
    logic                   count_en, lap_acc, wrap;
    logic [8:0]             frac_nxt;
    logic [5:0]             sec_nxt;
    logic [6:0]             min_nxt;

    // Saturating increment for the watchdog: holds at TIMEOUT_CYCLES.
    function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
        return (v == WD_MAX) ? v : v + 1'b1;
    endfunction

    // ---- stage p0/p1: synchroniser and edge history ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            prev_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], clk_512_in};
            prev_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    // Tick is formed from registered history, so it is glitch-free and one cycle wide.
    assign tick = sync_p0[SYNC_STAGES-1] & ~prev_p1;

    // ---- stage p2: control FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_RUN:            if (stop)  state_nxt = ST_PAUSE;
                ST_IDLE, ST_PAUSE: if (start) state_nxt = ST_RUN;
                default:           state_nxt = ST_IDLE;
            endcase
        end
    end

    assign running = (state == ST_RUN);

    // Counting follows the current state, so a start that arrives with a tick
    // in PAUSE does not count it, while a stop with a tick in RUN does.
    assign count_en = (state == ST_RUN) & tick & ~clear;
    assign lap_acc  = lap & ~clear & (state != ST_IDLE);
    assign wd_nxt   = tick ? '0 : wd_sat_inc(wd_cnt);

    always_comb begin
        frac_nxt = frac;
        sec_nxt  = sec;
        min_nxt  = min;
        wrap     = 1'b0;
        if (count_en) begin
            if (frac == FRAC_LAST) begin
                frac_nxt = '0;
                if (sec == 6'd59) begin
                    sec_nxt = '0;
                    if (min == MIN_LAST) begin
                        min_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        min_nxt = min + 7'd1;
                    end
                end else begin
                    sec_nxt = sec + 6'd1;
                end
            end else begin
                frac_nxt = frac + 9'd1;
            end
        end
    end

    // ---- stage p2: time, lap and watchdog registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac      <= '0;
            sec       <= '0;
            min       <= '0;
            lap_frac  <= '0;
            lap_sec   <= '0;
            lap_min   <= '0;
            lap_valid <= 1'b0;
            overflow  <= 1'b0;
            tick_lost <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            wd_cnt    <= wd_nxt;
            overflow  <= wrap;
            lap_valid <= lap_acc;
            if (clear) begin
                frac      <= '0;
                sec       <= '0;
                min       <= '0;
                lap_frac  <= '0;
                lap_sec   <= '0;
                lap_min   <= '0;
                tick_lost <= 1'b0;
            end else begin
                frac <= frac_nxt;
                sec  <= sec_nxt;
                min  <= min_nxt;
                // Lap takes the pre-increment time when it coincides with a tick.
                if (lap_acc) begin
                    lap_frac <= frac;
                    lap_sec  <= sec;
                    lap_min  <= min;
                end
                if (wd_nxt == WD_MAX) tick_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tick_stopwatch_512.sv
// -----------------------------------------------------------------------------
// tb_tick_stopwatch_512
//
// Drives two stopwatch instances from the same stimulus: one with default
// parameters and one with TICKS_PER_SEC=4 / TIMEOUT_CYCLES=100. Each has a
// reference model that keeps elapsed time as a single tick total and derives
// min/sec/frac arithmetically. Every cycle all outputs are compared against the
// models, plus directed checks with fixed expected values.
// -----------------------------------------------------------------------------
module tb_tick_stopwatch_512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_512_in = 1'b0;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;

    logic [8:0] frac_a, lap_frac_a, frac_b, lap_frac_b;
    logic [5:0] sec_a, lap_sec_a, sec_b, lap_sec_b;
    logic [6:0] min_a, lap_min_a, min_b, lap_min_b;
    logic       running_a, lap_valid_a, overflow_a, tick_lost_a;
    logic       running_b, lap_valid_b, overflow_b, tick_lost_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    tick_stopwatch_512 u_dflt (
        .clk(clk), .rst_n(rst_n), .clk_512_in(clk_512_in),
        .start(start), .stop(stop), .clear(clear), .lap(lap),
        .frac(frac_a), .sec(sec_a), .min(min_a), .running(running_a),
        .lap_frac(lap_frac_a), .lap_sec(lap_sec_a), .lap_min(lap_min_a),
        .lap_valid(lap_valid_a), .overflow(overflow_a), .tick_lost(tick_lost_a)
    );

    tick_stopwatch_512 #(.TICKS_PER_SEC(4), .MAX_MIN(99), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) u_small (
        .clk(clk), .rst_n(rst_n), .clk_512_in(clk_512_in),
        .start(start), .stop(stop), .clear(clear), .lap(lap),
        .frac(frac_b), .sec(sec_b), .min(min_b), .running(running_b),
        .lap_frac(lap_frac_b), .lap_sec(lap_sec_b), .lap_min(lap_min_b),
        .lap_valid(lap_valid_b), .overflow(overflow_b), .tick_lost(tick_lost_b)
    );

    // Reference model: state 0=idle 1=run 2=pause; time kept as total ticks.
    typedef struct packed {
        int       st;
        int       total;
        int       lap_total;
        bit       lap_v;
        bit       ovf;
        bit       lost;
        int       wd;
        bit [7:0] hist;   // hist[k] = clk_512_in sampled k+1 edges ago
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;

    function automatic mdl_t mstep(mdl_t m, bit x, bit s, bit p, bit c, bit l,
                                   int tps, int mm, int tmo);
        mdl_t n = m;
        // A rise seen through a 2-flop synchroniser counts two edges after sampling.
        bit tick = m.hist[1] & ~m.hist[2];
        n.hist  = {m.hist[6:0], x};
        n.ovf   = 1'b0;
        n.lap_v = 1'b0;
        n.wd    = tick ? 0 : ((m.wd < tmo) ? m.wd + 1 : tmo);
        if (c) begin
            n.st = 0; n.total = 0; n.lap_total = 0; n.lost = 1'b0;
        end else begin
            if (m.st == 1 && tick) begin
                n.total = m.total + 1;
                if (n.total == tps * 60 * (mm + 1)) begin
                    n.total = 0;
                    n.ovf   = 1'b1;
                end
            end
            if (l && m.st != 0) begin
                n.lap_total = m.total;
                n.lap_v     = 1'b1;
            end
            if (m.st == 1 && p)      n.st = 2;
            else if (m.st != 1 && s) n.st = 1;
            if (n.wd == tmo) n.lost = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mstep(ma, clk_512_in, start, stop, clear, lap, 512, 99, 400000);
            mb <= mstep(mb, clk_512_in, start, stop, clear, lap, 4, 99, 100);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string p, input mdl_t m, input int tps,
                           input logic [8:0] fr, input logic [5:0] se, input logic [6:0] mi,
                           input logic ru, input logic [8:0] lf, input logic [5:0] ls,
                           input logic [6:0] lm, input logic lv, input logic ov, input logic tl);
        chk({p, ".frac"},     32'(fr), 32'(m.total % tps));
        chk({p, ".sec"},      32'(se), 32'((m.total / tps) % 60));
        chk({p, ".min"},      32'(mi), 32'(m.total / (tps * 60)));
        chk({p, ".running"},  32'(ru), 32'(m.st == 1));
        chk({p, ".lap_frac"}, 32'(lf), 32'(m.lap_total % tps));
        chk({p, ".lap_sec"},  32'(ls), 32'((m.lap_total / tps) % 60));
        chk({p, ".lap_min"},  32'(lm), 32'(m.lap_total / (tps * 60)));
        chk({p, ".lap_valid"}, 32'(lv), 32'(m.lap_v));
        chk({p, ".overflow"}, 32'(ov), 32'(m.ovf));
        chk({p, ".tick_lost"}, 32'(tl), 32'(m.lost));
    endtask

    // One clock: compare all outputs just after the falling edge, then drive inputs.
    task automatic cyc(input bit x, input bit s, input bit p, input bit c, input bit l);
        @(negedge clk);
        cmp_all("dflt", ma, 512, frac_a, sec_a, min_a, running_a, lap_frac_a, lap_sec_a,
                lap_min_a, lap_valid_a, overflow_a, tick_lost_a);
        cmp_all("small", mb, 4, frac_b, sec_b, min_b, running_b, lap_frac_b, lap_sec_b,
                lap_min_b, lap_valid_b, overflow_b, tick_lost_b);
        clk_512_in = x; start = s; stop = p; clear = c; lap = l;
    endtask

    task automatic idle1();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        repeat (3) idle1();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle1();
        end
    endtask

    // Rising edge followed by a control pulse timed to land on the same edge as that tick.
    task automatic tick_with(input bit s, input bit p, input bit c, input bit l);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle1();
        cyc(1'b0, s, p, c, l);
    endtask

    task automatic async_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clk_512_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        #2;
        chk("areset.frac", 32'(frac_a), 32'd0);
        chk("areset.running", 32'(running_a), 32'd0);
        chk("areset.small_min", 32'(min_b), 32'd0);
        chk("areset.small_lost", 32'(tick_lost_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.frac", 32'(frac_a), 32'd0);
        chk("rst.sec", 32'(sec_a), 32'd0);
        chk("rst.min", 32'(min_a), 32'd0);
        chk("rst.running", 32'(running_a), 32'd0);
        chk("rst.lap_valid", 32'(lap_valid_a), 32'd0);
        chk("rst.tick_lost", 32'(tick_lost_b), 32'd0);
        rst_n = 1'b1;

        // Start, latency of the first count, then a full second.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle1();
        chk("t1.running", 32'(running_a), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle1();
        chk("t1.lat1", 32'(frac_a), 32'd0);
        idle1();
        chk("t1.lat2", 32'(frac_a), 32'd0);
        idle1();
        chk("t1.lat3", 32'(frac_a), 32'd1);
        ticks(510);
        settle();
        chk("t1.frac511", 32'(frac_a), 32'd511);
        chk("t1.sec0", 32'(sec_a), 32'd0);
        ticks(1);
        settle();
        chk("t1.frac_wrap", 32'(frac_a), 32'd0);
        chk("t1.sec1", 32'(sec_a), 32'd1);
        chk("t1.running2", 32'(running_a), 32'd1);

        // Run / pause / resume.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(100);
        settle();
        chk("t2.frac100", 32'(frac_a), 32'd100);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(50);
        settle();
        chk("t2.paused", 32'(frac_a), 32'd100);
        chk("t2.run0", 32'(running_a), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(10);
        settle();
        chk("t2.frac110", 32'(frac_a), 32'd110);
        tick_with(1'b0, 1'b1, 1'b0, 1'b0);
        idle1();
        chk("t2.stop_tick", 32'(frac_a), 32'd111);
        chk("t2.stop_run", 32'(running_a), 32'd0);
        tick_with(1'b1, 1'b0, 1'b0, 1'b0);
        idle1();
        chk("t2.start_tick", 32'(frac_a), 32'd111);
        chk("t2.start_run", 32'(running_a), 32'd1);
        settle();

        // Lap capture.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(20);
        settle();
        tick_with(1'b0, 1'b0, 1'b0, 1'b1);
        idle1();
        chk("t4.lap_frac", 32'(lap_frac_a), 32'd20);
        chk("t4.frac", 32'(frac_a), 32'd21);
        chk("t4.lap_valid", 32'(lap_valid_a), 32'd1);
        idle1();
        chk("t4.lap_valid_end", 32'(lap_valid_a), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4.b2b_1", 32'(lap_valid_a), 32'd1);
        idle1();
        chk("t4.b2b_2", 32'(lap_valid_a), 32'd1);
        idle1();
        chk("t4.b2b_end", 32'(lap_valid_a), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle1();
        chk("t4.idle_lap", 32'(lap_valid_a), 32'd0);
        chk("t4.idle_lap_frac", 32'(lap_frac_a), 32'd0);

        // clear + start + tick together in RUN.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        settle();
        tick_with(1'b1, 1'b0, 1'b1, 1'b0);
        idle1();
        chk("t6.running", 32'(running_a), 32'd0);
        chk("t6.frac", 32'(frac_a), 32'd0);
        chk("t6.sec", 32'(sec_a), 32'd0);
        chk("t6.min", 32'(min_a), 32'd0);

        // Watchdog on the small instance.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (50) idle1();
        chk("t5.not_yet", 32'(tick_lost_b), 32'd0);
        repeat (60) idle1();
        chk("t5.lost", 32'(tick_lost_b), 32'd1);
        chk("t5.dflt_ok", 32'(tick_lost_a), 32'd0);
        ticks(5);
        settle();
        chk("t5.sticky", 32'(tick_lost_b), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle1();
        chk("t5.cleared", 32'(tick_lost_b), 32'd0);

        // Full-range wrap on the small instance: 99:59:3 -> 0:00:0.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(23999);
        settle();
        chk("t3.min99", 32'(min_b), 32'd99);
        chk("t3.sec59", 32'(sec_b), 32'd59);
        chk("t3.frac3", 32'(frac_b), 32'd3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle1();
        idle1();
        idle1();
        chk("t3.ovf", 32'(overflow_b), 32'd1);
        chk("t3.wrap_min", 32'(min_b), 32'd0);
        chk("t3.wrap_frac", 32'(frac_b), 32'd0);
        idle1();
        chk("t3.ovf_end", 32'(overflow_b), 32'd0);

        // Randomised traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            cyc(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 7) == 0));
        end
        settle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
